// File: rtl/mul_pkg.sv
// Shared function codes and FSM encoding for the ALU-control multiply protocol.
// ALU control and the multiply unit both import this so the codes cannot drift.
package mul_pkg;
  localparam logic [5:0] FN_MULTU     = 6'b011001;
  localparam logic [5:0] FN_MFHI      = 6'b010000;
  localparam logic [5:0] FN_MFLO      = 6'b010010;
  localparam logic [5:0] FN_ADD       = 6'b100000;
  localparam logic [5:0] FN_OPEN_HILO = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_t;
endpackage

// File: rtl/radix4_step.sv
// One shift-add step: retires DIGIT_BITS multiplier bits into the {acc, mplier} pair.
module radix4_step #(
  parameter int WIDTH      = 32,
  parameter int DIGIT_BITS = 2
) (
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mplier,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mplier
);
  localparam int SW = WIDTH + DIGIT_BITS;

  logic [DIGIT_BITS-1:0] w_digit;
  logic [SW-1:0]         w_sum;

  // acc + mcand*d < 2^SW, so the widened sum never loses a carry
  assign w_digit  = i_mplier[DIGIT_BITS-1:0];
  assign w_sum    = SW'(i_acc) + SW'(i_mcand) * SW'(w_digit);
  assign o_acc    = w_sum[SW-1:DIGIT_BITS];
  assign o_mplier = {w_sum[DIGIT_BITS-1:0], i_mplier[WIDTH-1:DIGIT_BITS]};
endmodule

// File: rtl/multu_hilo_unit.sv
// Unsigned sequential multiplier with Hi/Lo commit and MFHI/MFLO read mux,
// driven by the ALU control function code and mulreset.
module multu_hilo_unit
  import mul_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter int         DIGIT_BITS = 2,
  parameter logic [5:0] OPEN_HILO  = FN_OPEN_HILO
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_signal,
  input  logic             i_mulreset,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_late_err,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_data_out
);
  localparam int             STEPS = WIDTH / DIGIT_BITS;
  localparam int             SCW   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SCW-1:0] LAST  = SCW'(STEPS - 1);

  if (WIDTH % DIGIT_BITS != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of DIGIT_BITS");
  end

  mul_state_t       r_state, w_nxt;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, r_hi, r_lo;
  logic [WIDTH-1:0] w_acc_nxt, w_mplier_nxt;
  logic [SCW-1:0]   r_step;
  logic             r_late_err;
  logic             w_ld, w_step_en, w_commit, w_late;

  radix4_step #(.WIDTH(WIDTH), .DIGIT_BITS(DIGIT_BITS)) u_step (
    .i_mcand  (r_mcand),
    .i_acc    (r_acc),
    .i_mplier (r_mplier),
    .o_acc    (w_acc_nxt),
    .o_mplier (w_mplier_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_nxt;
  end

  // mulreset wins over every function code in every state
  always_comb begin
    w_nxt     = r_state;
    w_ld      = 1'b0;
    w_step_en = 1'b0;
    w_commit  = 1'b0;
    w_late    = 1'b0;
    if (i_mulreset) begin
      w_ld  = 1'b1;
      w_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: w_late = (i_signal == OPEN_HILO);
        ST_LOAD: begin
          w_late = (i_signal == OPEN_HILO);
          w_nxt  = (i_signal == FN_MULTU) ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (i_signal == FN_MULTU) begin
            w_step_en = 1'b1;
            if (r_step == LAST) w_nxt = ST_DONE;
          end else begin
            w_late = (i_signal == OPEN_HILO);
            w_nxt  = ST_IDLE;
          end
        end
        ST_DONE: begin
          if (i_signal != FN_MULTU) begin
            w_commit = (i_signal == OPEN_HILO);
            w_nxt    = ST_IDLE;
          end
        end
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_step     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_late_err <= 1'b0;
    end else begin
      r_late_err <= w_late;
      if (w_ld) begin
        r_mcand  <= i_data_a;
        r_mplier <= i_data_b;
        r_acc    <= '0;
        r_step   <= '0;
      end else if (w_step_en) begin
        r_acc    <= w_acc_nxt;
        r_mplier <= w_mplier_nxt;
        r_step   <= r_step + 1'b1;
      end
      // after the last step the low product half has shifted fully into mplier
      if (w_commit) begin
        r_hi <= r_acc;
        r_lo <= r_mplier;
      end
    end
  end

  assign o_busy     = (r_state == ST_RUN);
  assign o_done     = (r_state == ST_DONE);
  assign o_late_err = r_late_err;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

  always_comb begin
    case (i_signal)
      FN_MFHI: o_data_out = r_hi;
      FN_MFLO: o_data_out = r_lo;
      default: o_data_out = '0;
    endcase
  end
endmodule

// File: tb/tb_multu_hilo_unit.sv
// Bench for multu_hilo_unit: vector table, hand-built corner sequences and
// random operands checked against a plain 64-bit multiply reference.
module tb_multu_hilo_unit;
  import mul_pkg::*;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   sig = 6'h0;
  logic         mulreset = 1'b0;
  logic [W-1:0] da = '0, db = '0;
  logic         busy, done, late_err;
  logic [W-1:0] hi, lo, data_out;

  int           total = 0, bad = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  typedef struct {
    logic [W-1:0] a, b, hi, lo;
    bit           use_ctrl;
  } vec_t;
  vec_t tbl[6];

  multu_hilo_unit #(.WIDTH(W), .DIGIT_BITS(2), .OPEN_HILO(FN_OPEN_HILO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_signal(sig), .i_mulreset(mulreset),
    .i_data_a(da), .i_data_b(db), .o_busy(busy), .o_done(done),
    .o_late_err(late_err), .o_hi(hi), .o_lo(lo), .o_data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic commit_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    m_hi = p[63:32];
    m_lo = p[31:0];
  endtask

  task automatic load2(input logic [W-1:0] a, input logic [W-1:0] b);
    mulreset = 1'b1; sig = FN_MULTU; da = a; db = b;
    tick(); tick();
    mulreset = 1'b0;
  endtask

  task automatic check_reads(input string tag);
    sig = FN_MFLO; #1 chk({tag, "_mflo"}, 64'(data_out), 64'(m_lo));
    sig = FN_MFHI; #1 chk({tag, "_mfhi"}, 64'(data_out), 64'(m_hi));
    sig = FN_ADD;  #1 chk({tag, "_other"}, 64'(data_out), 64'd0);
    sig = 6'h0;
  endtask

  // direct drive: 2-cycle mulreset, MULTU until done, then OPEN_HILO
  task automatic full_run(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int n;
    load2(a, b);
    tick();
    chk({tag, "_busy_start"}, 64'(busy), 64'd1);
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    chk({tag, "_busy_len"}, 64'(n), 64'd16);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
    sig = FN_OPEN_HILO;
    tick();
    commit_model(a, b);
    chk({tag, "_commit"}, {hi, lo}, {m_hi, m_lo});
    chk({tag, "_post"}, {62'd0, done, late_err}, 64'd0);
    check_reads(tag);
  endtask

  // ALU control timing: mulreset on its 1st clock, MULTU after, OPEN_HILO on its 32nd
  task automatic ctrl_run(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    for (int c = 1; c <= 32; c++) begin
      mulreset = (c == 1);
      sig = (c == 32) ? FN_OPEN_HILO : FN_MULTU;
      da = a; db = b;
      if (c == 32) begin
        #1;
        chk({tag, "_pre_done"}, 64'(done), 64'd1);
        chk({tag, "_pre_hold"}, {hi, lo}, {m_hi, m_lo});
      end
      tick();
    end
    commit_model(a, b);
    chk({tag, "_commit"}, {hi, lo}, {m_hi, m_lo});
    chk({tag, "_late"}, 64'(late_err), 64'd0);
    check_reads(tag);
  endtask

  initial begin
    tbl[0] = '{32'd3,        32'd5,        32'h0,        32'd15,       1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[2] = '{32'h00010000, 32'h00010000, 32'h1,        32'h0,        1'b0};
    tbl[3] = '{32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 32'h242D2080, 1'b1};
    tbl[4] = '{32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        1'b1};
    tbl[5] = '{32'h1,        32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 1'b0};

    #1;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_flags", {61'd0, busy, done, late_err}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (tbl[i].use_ctrl) ctrl_run(tbl[i].a, tbl[i].b, tag);
      else                 full_run(tbl[i].a, tbl[i].b, tag);
      chk({tag, "_table"}, {hi, lo}, {tbl[i].hi, tbl[i].lo});
    end

    // early commit after 10 RUN cycles
    load2(32'h00000BAD, 32'h0000F00D);
    tick();
    repeat (10) tick();
    chk("early_busy", 64'(busy), 64'd1);
    sig = FN_OPEN_HILO;
    tick();
    chk("early_late", 64'(late_err), 64'd1);
    chk("early_idle", {62'd0, busy, done}, 64'd0);
    chk("early_hold", {hi, lo}, {m_hi, m_lo});
    sig = 6'h0;
    tick();
    chk("early_pulse", 64'(late_err), 64'd0);

    // abort via ADD mid-RUN, then a clean run
    load2(32'h77777777, 32'h88888888);
    tick();
    repeat (5) tick();
    sig = FN_ADD;
    tick();
    chk("abort_idle", {62'd0, busy, done}, 64'd0);
    chk("abort_hold", {hi, lo}, {m_hi, m_lo});
    full_run(32'h00010000, 32'h00010000, "after_abort");
    chk("after_abort_val", {hi, lo}, 64'h00000001_00000000);

    // product discarded when DONE sees a non-commit code
    load2(32'hCAFEF00D, 32'h0000ABCD);
    tick();
    for (int n = 0; n < 40 && !done; n++) tick();
    chk("disc_done", 64'(done), 64'd1);
    sig = FN_MFHI;
    tick();
    chk("disc_idle", 64'(done), 64'd0);
    sig = FN_OPEN_HILO;
    tick();
    chk("disc_late", 64'(late_err), 64'd1);
    chk("disc_hold", {hi, lo}, {m_hi, m_lo});
    sig = 6'h0;
    tick();

    // async reset 5 cycles into RUN
    load2(32'h13579BDF, 32'h2468ACE0);
    tick();
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("rst_run_hilo", {hi, lo}, 64'd0);
    chk("rst_run_busy", 64'(busy), 64'd0);
    sig = 6'h0;
    @(negedge clk);
    rst_n = 1'b1;
    sig = FN_OPEN_HILO;
    tick();
    chk("rst_late", 64'(late_err), 64'd1);
    chk("rst_nocommit", {hi, lo}, 64'd0);
    sig = 6'h0;
    tick();

    // random operands against the 64-bit reference multiply
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] a, b;
      a = $urandom();
      b = $urandom();
      if (i % 5 == 4) a = 32'hFFFFFFFF;
      if (i % 2 == 0) ctrl_run(a, b, $sformatf("rnd%0d", i));
      else            full_run(a, b, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
